// File: rtl/line_buffer_apbif.sv
// APB3 slave front-end for line_buffer_reg: setup/access tracking with WAIT_CYC wait
// states, one-hot register selects, a single-cycle write strobe and readback mux.
module line_buffer_apbif #(
    parameter int ADDR_W   = 12,
    parameter int WAIT_CYC = 1
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic              pready,
    output logic [31:0]       prdata,
    output logic              pslverr,
    output logic              apbif_wr,
    output logic [31:0]       apbif_wdata,
    output logic              ctrl_ff_sel,
    output logic              real_depth_ff_sel,
    output logic              line_wr_ff_sel,
    output logic              ram_base_ff_sel,
    output logic              ram_base_offset_ff_sel,
    output logic              actived_chnl_ff_sel,
    output logic              actived_chnl_bits_ff_sel,
    output logic              inactived_chnl_bits_ff_sel,
    output logic              ro_test_ff_sel,
    input  logic [5:0]        ctrl_ff,
    input  logic [15:0]       real_depth_ff,
    input  logic [15:0]       line_wr_ff,
    input  logic [31:0]       ram_base_ff,
    input  logic [31:0]       ram_base_offset_ff,
    input  logic [15:0]       actived_chnl_ff,
    input  logic [31:0]       actived_chnl_bits_ff,
    input  logic [15:0]       inactived_chnl_bits_ff,
    input  logic [23:0]       ro_test_ff
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYC);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [8:0]  sel_q, sel_d;
    logic        err_q, err_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] wdata_q, wdata_d;

    logic [8:0]  dec_sel;
    logic        dec_err;
    logic        pready_c;

    // Registers live at word offsets 0x00..0x20; everything else is an error.
    always_comb begin
        dec_sel = '0;
        dec_err = 1'b1;
        if ((paddr[ADDR_W-1:6] == '0) && (paddr[1:0] == 2'b00) && (paddr[5:2] <= 4'd8)) begin
            dec_err             = 1'b0;
            dec_sel[paddr[5:2]] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        err_d    = err_q;
        pwrite_d = pwrite_q;
        wdata_d  = wdata_q;
        pready_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d  = ACCESS;
                    cnt_d    = WAIT_INIT;
                    sel_d    = dec_sel;
                    err_d    = dec_err;
                    pwrite_d = pwrite;
                    wdata_d  = pwdata;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (penable) begin
                    if (cnt_q != 3'd0) begin
                        cnt_d = cnt_q - 3'd1;
                    end else begin
                        pready_c = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            err_q    <= 1'b0;
            pwrite_q <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            err_q    <= err_d;
            pwrite_q <= pwrite_d;
            wdata_q  <= wdata_d;
        end
    end

    logic [8:0] sel_out;
    assign sel_out = (state_q == ACCESS) ? sel_q : 9'd0;

    assign pready      = pready_c;
    assign pslverr     = pready_c & err_q;
    assign apbif_wr    = pready_c & pwrite_q & ~err_q;
    assign apbif_wdata = wdata_q;

    assign ctrl_ff_sel                = sel_out[0];
    assign real_depth_ff_sel          = sel_out[1];
    assign line_wr_ff_sel             = sel_out[2];
    assign ram_base_ff_sel            = sel_out[3];
    assign ram_base_offset_ff_sel     = sel_out[4];
    assign actived_chnl_ff_sel        = sel_out[5];
    assign actived_chnl_bits_ff_sel   = sel_out[6];
    assign inactived_chnl_bits_ff_sel = sel_out[7];
    assign ro_test_ff_sel             = sel_out[8];

    // sel_q is one-hot (or zero on error), so an AND-OR mux suffices.
    always_comb begin
        prdata = '0;
        if (pready_c && !pwrite_q && !err_q) begin
            prdata = ({26'd0, ctrl_ff}                & {32{sel_q[0]}})
                   | ({16'd0, real_depth_ff}          & {32{sel_q[1]}})
                   | ({16'd0, line_wr_ff}             & {32{sel_q[2]}})
                   | (ram_base_ff                     & {32{sel_q[3]}})
                   | (ram_base_offset_ff              & {32{sel_q[4]}})
                   | ({16'd0, actived_chnl_ff}        & {32{sel_q[5]}})
                   | (actived_chnl_bits_ff            & {32{sel_q[6]}})
                   | ({16'd0, inactived_chnl_bits_ff} & {32{sel_q[7]}})
                   | ({8'd0, ro_test_ff}              & {32{sel_q[8]}});
        end
    end

endmodule
